// File: rtl/seg7_scan.sv
// -----------------------------------------------------------------------------
// seg7_scan -- four-digit multiplexed seven-segment display driver.
//
// A divided scan clock (sclk) from the upstream divider is used as a strobe:
// every rising edge of sclk advances to the next digit. Between digits the
// display is held dark for BLANK_CYCLES clk cycles to suppress ghosting.
// The displayed value, decimal points and enables are captured into shadow
// registers once per frame (when the scan wraps from digit 3 to digit 0), so
// a value changing mid-frame never tears across digits.
//
// Parameters
//   BLANK_CYCLES  dark cycles after each digit step (1..255)
//   ACTIVE_LOW    1: an/seg/dp driven active-low (common anode), 0: active-high
//
// Ports
//   clk         in   1   system clock, all state on its rising edge
//   rst         in   1   synchronous reset, active-high
//   sclk        in   1   scan strobe from the divider (already in clk domain)
//   value       in  16   digit k shows value[4k+3:4k]
//   dp_in       in   4   decimal point per digit, 1 = lit
//   digit_en    in   4   per-digit enable, 0 = digit dark
//   an          out  4   digit anodes, at most one active
//   seg         out  7   segments, gfedcba (bit 6 = g)
//   dp          out  1   decimal point segment
//   frame_done  out  1   one-cycle pulse when a new frame's inputs are latched
// -----------------------------------------------------------------------------
module seg7_scan #(
  parameter int unsigned BLANK_CYCLES = 16,
  parameter bit          ACTIVE_LOW   = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        sclk,
  input  logic [15:0] value,
  input  logic [3:0]  dp_in,
  input  logic [3:0]  digit_en,
  output logic [3:0]  an,
  output logic [6:0]  seg,
  output logic        dp,
  output logic        frame_done
);

  // Physical "off" levels for each output group, in board polarity.
  localparam logic [3:0] AN_OFF  = ACTIVE_LOW ? 4'hF  : 4'h0;
  localparam logic [6:0] SEG_OFF = ACTIVE_LOW ? 7'h7F : 7'h00;
  localparam logic       DP_OFF  = ACTIVE_LOW ? 1'b1  : 1'b0;

  // Terminal count of the blanking counter.
  localparam logic [7:0] BLANK_LAST = 8'(BLANK_CYCLES - 1);

  typedef enum logic {
    ST_BLANK = 1'b0,
    ST_SHOW  = 1'b1
  } state_t;

  // Active-high gfedcba pattern for one hex nibble.
  function automatic logic [6:0] hex_decode(input logic [3:0] nib);
    logic [6:0] pat;
    case (nib)
      4'h0: pat = 7'h3F;
      4'h1: pat = 7'h06;
      4'h2: pat = 7'h5B;
      4'h3: pat = 7'h4F;
      4'h4: pat = 7'h66;
      4'h5: pat = 7'h6D;
      4'h6: pat = 7'h7D;
      4'h7: pat = 7'h07;
      4'h8: pat = 7'h7F;
      4'h9: pat = 7'h6F;
      4'hA: pat = 7'h77;
      4'hB: pat = 7'h7C;
      4'hC: pat = 7'h39;
      4'hD: pat = 7'h5E;
      4'hE: pat = 7'h79;
      default: pat = 7'h71;
    endcase
    return pat;
  endfunction

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic        r_sclk_q;
  logic [1:0]  r_idx;
  state_t      r_state;
  logic [7:0]  r_cnt;

  // Per-frame shadow copies of the display inputs.
  logic [15:0] r_value;
  logic [3:0]  r_dp;
  logic [3:0]  r_en;

  // Registered outputs, held in board polarity.
  logic [3:0]  r_an;
  logic [6:0]  r_seg;
  logic        r_dp_out;
  logic        r_frame_done;

  // ---------------------------------------------------------------------------
  // Combinational helpers
  // ---------------------------------------------------------------------------
  logic        w_step;
  logic [3:0]  w_nibble;
  logic [3:0]  w_an_drv;
  logic [6:0]  w_seg_drv;
  logic        w_dp_drv;

  // Exactly one step per sclk rising edge; a held-high level or a falling
  // edge produces nothing.
  assign w_step = sclk & ~r_sclk_q;

  assign w_nibble = r_value[{r_idx, 2'b00} +: 4];

  // Output pattern for the current digit, taken from the shadow registers so
  // it is stable for the whole frame. A disabled digit stays fully dark.
  // NOTE: every signal assigned in always_comb gets a default first, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    w_an_drv  = AN_OFF;
    w_seg_drv = SEG_OFF;
    w_dp_drv  = DP_OFF;
    if (r_en[r_idx]) begin
      w_an_drv  = AN_OFF ^ (4'b0001 << r_idx);
      w_seg_drv = SEG_OFF ^ hex_decode(w_nibble);
      w_dp_drv  = DP_OFF ^ r_dp[r_idx];
    end
  end

  // ---------------------------------------------------------------------------
  // Scan sequencer
  // ---------------------------------------------------------------------------
  // NOTE: all state here uses non-blocking assignments so every register
  // samples the pre-edge values of the others, regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sclk_q     <= 1'b0;
      r_idx        <= 2'd3;
      r_state      <= ST_BLANK;
      r_cnt        <= 8'd0;
      r_value      <= 16'h0000;
      r_dp         <= 4'h0;
      r_en         <= 4'h0;
      r_an         <= AN_OFF;
      r_seg        <= SEG_OFF;
      r_dp_out     <= DP_OFF;
      r_frame_done <= 1'b0;
    end else begin
      r_sclk_q     <= sclk;
      r_frame_done <= 1'b0;

      if (w_step) begin
        // A step always restarts blanking, even mid-blank, so the digit that
        // was pending is dropped and never reaches the display.
        r_idx    <= r_idx + 2'd1;
        r_state  <= ST_BLANK;
        r_cnt    <= 8'd0;
        r_an     <= AN_OFF;
        r_seg    <= SEG_OFF;
        r_dp_out <= DP_OFF;

        // Leaving digit 3 means digit 0 of a new frame is next: capture the
        // inputs now so the whole frame is drawn from one consistent value.
        if (r_idx == 2'd3) begin
          r_value      <= value;
          r_dp         <= dp_in;
          r_en         <= digit_en;
          r_frame_done <= 1'b1;
        end
      end else begin
        case (r_state)
          ST_BLANK: begin
            if (r_cnt == BLANK_LAST) begin
              // Load the pattern on the same edge as the state change so the
              // outputs are valid from the first SHOW cycle.
              r_state  <= ST_SHOW;
              r_an     <= w_an_drv;
              r_seg    <= w_seg_drv;
              r_dp_out <= w_dp_drv;
            end else begin
              r_cnt <= r_cnt + 8'd1;
            end
          end
          ST_SHOW: begin
            // Outputs hold until the next step.
          end
          default: begin
            r_state <= ST_BLANK;
            r_cnt   <= 8'd0;
          end
        endcase
      end
    end
  end

  assign an         = r_an;
  assign seg        = r_seg;
  assign dp         = r_dp_out;
  assign frame_done = r_frame_done;

endmodule

// File: tb/tb_seg7_scan.sv
// -----------------------------------------------------------------------------
// tb_seg7_scan -- directed self-checking bench for seg7_scan
// (BLANK_CYCLES=16, ACTIVE_LOW=1). Expected values are hand-computed
// inverted hex patterns. Inputs change on the falling clock edge and outputs
// are sampled there as well, away from the active edge.
// -----------------------------------------------------------------------------
module tb_seg7_scan;

  localparam int BLANK = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic        sclk;
  logic [15:0] value;
  logic [3:0]  dp_in;
  logic [3:0]  digit_en;
  logic [3:0]  an;
  logic [6:0]  seg;
  logic        dp;
  logic        frame_done;

  int n_cmp = 0;
  int n_err = 0;
  bit inv_on = 1'b0;

  always #5 clk = ~clk;

  seg7_scan #(.BLANK_CYCLES(BLANK), .ACTIVE_LOW(1'b1)) dut (
    .clk        (clk),
    .rst        (rst),
    .sclk       (sclk),
    .value      (value),
    .dp_in      (dp_in),
    .digit_en   (digit_en),
    .an         (an),
    .seg        (seg),
    .dp         (dp),
    .frame_done (frame_done)
  );

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // At most one anode may be active (low) in any cycle.
  always @(negedge clk) begin
    if (inv_on)
      check("an_onehot", 16'($countones(~an) <= 1), 16'd1);
  end

  task automatic wait_cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Produce one sclk rising edge; the DUT sees it at the next posedge.
  task automatic sclk_edge();
    @(negedge clk) sclk = 1'b0;
    @(negedge clk) sclk = 1'b1;
  endtask

  task automatic check_dark(input string tag);
    check({tag, "_an"},  16'(an),  16'hF);
    check({tag, "_seg"}, 16'(seg), 16'h7F);
    check({tag, "_dp"},  16'(dp),  16'h1);
  endtask

  // One scan step: frame_done one cycle after the edge, dark for BLANK
  // cycles, then the expected digit from cycle BLANK+1, held thereafter.
  task automatic step_and_check(input string tag, input logic exp_fd,
                                input logic [3:0] e_an, input logic [6:0] e_seg,
                                input logic e_dp);
    sclk_edge();
    wait_cycles(1);
    check({tag, "_fd"}, 16'(frame_done), 16'(exp_fd));
    check_dark({tag, "_blank0"});
    wait_cycles(1);
    check({tag, "_fd_off"}, 16'(frame_done), 16'h0);
    wait_cycles(BLANK - 2);
    check_dark({tag, "_blank_end"});
    wait_cycles(1);
    check({tag, "_an"},  16'(an),  16'(e_an));
    check({tag, "_seg"}, 16'(seg), 16'(e_seg));
    check({tag, "_dp"},  16'(dp),  16'(e_dp));
    // Hold, including across a falling sclk edge which must be ignored.
    wait_cycles(30);
    sclk = 1'b0;
    wait_cycles(30);
    check({tag, "_hold_an"},  16'(an),  16'(e_an));
    check({tag, "_hold_seg"}, 16'(seg), 16'(e_seg));
  endtask

  initial begin
    rst      = 1'b1;
    sclk     = 1'b0;
    value    = 16'h0000;
    dp_in    = 4'h0;
    digit_en = 4'h0;

    // 1. Reset held 3 cycles with sclk toggling.
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      inv_on = 1'b1;
      check_dark("reset");
      check("reset_fd", 16'(frame_done), 16'h0);
      sclk = ~sclk;
    end
    @(negedge clk);
    rst  = 1'b0;
    sclk = 1'b0;
    wait_cycles(40);
    check_dark("idle_after_reset");

    // 2. Basic scan of 16'h12AF, all digits enabled, no dp.
    value    = 16'h12AF;
    digit_en = 4'hF;
    dp_in    = 4'h0;
    step_and_check("d0_F", 1'b1, 4'hE, 7'h0E, 1'b1);
    step_and_check("d1_A", 1'b0, 4'hD, 7'h08, 1'b1);

    // 3. New value while digit 1 is shown: no effect until the next wrap.
    value = 16'h0000;
    step_and_check("d2_2", 1'b0, 4'hB, 7'h24, 1'b1);
    step_and_check("d3_1", 1'b0, 4'h7, 7'h79, 1'b1);
    step_and_check("d0_0", 1'b1, 4'hE, 7'h40, 1'b1);

    // 4. Second sclk edge 5 cycles after the first, inside blanking.
    sclk_edge();
    for (int i = 0; i < 3; i++) begin
      wait_cycles(1);
      check("blank_restart_an", 16'(an), 16'hF);
    end
    sclk_edge();
    for (int i = 0; i < BLANK; i++) begin
      wait_cycles(1);
      check("blank_restart2_an", 16'(an), 16'hF);
    end
    wait_cycles(1);
    check("restart_an",  16'(an),  16'hB);
    check("restart_seg", 16'(seg), 16'h40);

    // 5. Enables 0101, dp on digit 0, value 16'h8421.
    value    = 16'h8421;
    digit_en = 4'b0101;
    dp_in    = 4'b0001;
    step_and_check("en_d3_old", 1'b0, 4'h7, 7'h40, 1'b1);
    step_and_check("en_d0",     1'b1, 4'hE, 7'h79, 1'b0);
    step_and_check("en_d1",     1'b0, 4'hF, 7'h7F, 1'b1);
    step_and_check("en_d2",     1'b0, 4'hB, 7'h19, 1'b1);
    step_and_check("en_d3",     1'b0, 4'hF, 7'h7F, 1'b1);
    step_and_check("en_d0b",    1'b1, 4'hE, 7'h79, 1'b0);
    step_and_check("en_d1b",    1'b0, 4'hF, 7'h7F, 1'b1);
    step_and_check("en_d2b",    1'b0, 4'hB, 7'h19, 1'b1);

    // 6. One-cycle reset while digit 2 is shown.
    @(negedge clk);
    rst  = 1'b1;
    sclk = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    check_dark("midrst");
    check("midrst_fd", 16'(frame_done), 16'h0);
    for (int i = 0; i < 20; i++) begin
      wait_cycles(1);
      check("midrst_dark_an", 16'(an), 16'hF);
    end
    step_and_check("post_rst_d0", 1'b1, 4'hE, 7'h79, 1'b0);
    step_and_check("post_rst_d1", 1'b0, 4'hF, 7'h7F, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
